// File: rtl/cpu_control.sv
// Multicycle FETCH/EXEC/MEM controller for the 16-bit CR16-style datapath (reg_alu).
// Optional memory-wait timeout with a sticky mem_err flag: define CPU_CONTROL_MEM_TIMEOUT_EN.
module cpu_control #(
    parameter logic [15:0] RESET_PC = 16'h0000
`ifdef CPU_CONTROL_MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic [15:0] dSrc,
    input  logic [15:0] dDst,
    input  logic [4:0]  psr,
    output logic        write,
    output logic        IMM_MUX,
    output logic        SRAM_OUT,
    output logic        RA_BUF,
    output logic [3:0]  rSrc,
    output logic [3:0]  rDst,
    output logic [4:0]  aluOp,
    output logic [15:0] imm,
    output logic [15:0] pc,
    output logic        mem_err
);

    localparam logic [4:0] ALUOp_NOP = 5'd0;
    localparam logic [4:0] ALUOp_AND = 5'd1;
    localparam logic [4:0] ALUOp_OR  = 5'd2;
    localparam logic [4:0] ALUOp_XOR = 5'd3;
    localparam logic [4:0] ALUOp_ADD = 5'd5;
    localparam logic [4:0] ALUOp_SUB = 5'd9;
    localparam logic [4:0] ALUOp_CMP = 5'd11;
    localparam logic [4:0] ALUOp_MOV = 5'd13;
    localparam logic [4:0] ALUOp_LUI = 5'd15;
    localparam logic [4:0] ALUOp_SLL = 5'd16;
    localparam logic [4:0] ALUOp_SRA = 5'd17;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        tmo;

    // Flags arrive as {C,Z,F,L,N}.
    function automatic logic cond_taken(input logic [3:0] cond, input logic [4:0] flags);
        logic c, z, f, l, n;
        {c, z, f, l, n} = flags;
        case (cond)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return c;
            4'b0011: return !c;
            4'b0110: return n;
            4'b0111: return !n;
            4'b1000: return f;
            4'b1001: return !f;
            4'b1010: return l;
            4'b1011: return !l;
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Shared by register ALU (keyed on ext) and immediate forms (keyed on op): {valid, aluOp}.
    function automatic logic [5:0] alu_sel(input logic [3:0] code);
        case (code)
            4'b0001: return {1'b1, ALUOp_AND};
            4'b0010: return {1'b1, ALUOp_OR};
            4'b0011: return {1'b1, ALUOp_XOR};
            4'b0101: return {1'b1, ALUOp_ADD};
            4'b1001: return {1'b1, ALUOp_SUB};
            4'b1011: return {1'b1, ALUOp_CMP};
            4'b1101: return {1'b1, ALUOp_MOV};
            default: return {1'b0, ALUOp_NOP};
        endcase
    endfunction

    logic [3:0]  op, rd, ext, rs;
    logic [15:0] zext8, sext8;
    logic [5:0]  reg_sel, imm_sel;

    assign op      = ir_q[15:12];
    assign rd      = ir_q[11:8];
    assign ext     = ir_q[7:4];
    assign rs      = ir_q[3:0];
    assign zext8   = {8'h00, ir_q[7:0]};
    assign sext8   = {{8{ir_q[7]}}, ir_q[7:0]};
    assign reg_sel = alu_sel(ext);
    assign imm_sel = alu_sel(op);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        write     = 1'b0;
        IMM_MUX   = 1'b0;
        SRAM_OUT  = 1'b0;
        RA_BUF    = 1'b0;
        rSrc      = 4'h0;
        rDst      = 4'h0;
        aluOp     = ALUOp_NOP;
        imm       = 16'h0000;
        pc        = pc_q;

        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = ST_EXEC;
                end else if (tmo) begin
                    ir_d = 16'h0000;
                end
            end

            ST_EXEC: begin
                pc_d    = pc_q + 16'd1;
                state_d = ST_FETCH;
                if (op == 4'b0000) begin
                    if (reg_sel[5]) begin
                        write = (ext != 4'b1011);
                        rSrc  = rs;
                        rDst  = rd;
                        aluOp = reg_sel[4:0];
                    end
                end else if (imm_sel[5]) begin
                    IMM_MUX = 1'b1;
                    rDst    = rd;
                    aluOp   = imm_sel[4:0];
                    imm     = (op inside {4'b0001, 4'b0010, 4'b0011}) ? zext8 : sext8;
                    write   = (op != 4'b1011);
                end else begin
                    case (op)
                        4'b1111: begin
                            IMM_MUX = 1'b1;
                            rDst    = rd;
                            aluOp   = ALUOp_LUI;
                            imm     = zext8;
                            write   = 1'b1;
                        end
                        4'b1000: begin
                            if (ext == 4'b0000 || ext == 4'b0001) begin
                                IMM_MUX = 1'b1;
                                rDst    = rd;
                                aluOp   = (ext == 4'b0000) ? ALUOp_SLL : ALUOp_SRA;
                                imm     = {12'h000, rs};
                                write   = 1'b1;
                            end
                        end
                        4'b0100: begin
                            case (ext)
                                4'b0000, 4'b0100: begin
                                    rSrc    = rs;
                                    rDst    = rd;
                                    state_d = ST_MEM;
                                end
                                4'b1000: begin
                                    write  = 1'b1;
                                    RA_BUF = 1'b1;
                                    rSrc   = rs;
                                    rDst   = rd;
                                    pc     = pc_q + 16'd1;
                                    pc_d   = dSrc;
                                end
                                4'b1100: begin
                                    rSrc = rs;
                                    if (cond_taken(rd, psr)) pc_d = dSrc;
                                end
                                default: ;
                            endcase
                        end
                        4'b1100: begin
                            if (cond_taken(rd, psr)) pc_d = pc_q + sext8;
                        end
                        default: ;
                    endcase
                end
            end

            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (ext == 4'b0100);
                mem_addr  = dSrc;
                mem_wdata = dDst;
                rSrc      = rs;
                rDst      = rd;
                if (mem_ack) begin
                    state_d = ST_FETCH;
                    if (ext == 4'b0000) begin
                        write    = 1'b1;
                        SRAM_OUT = 1'b1;
                    end
                end else if (tmo) begin
                    state_d = ST_FETCH;
                end
            end

            default: state_d = ST_FETCH;
        endcase

        // Outputs are forced quiet for the whole reset cycle, even mid-access.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = 16'h0000;
            mem_wdata = 16'h0000;
            write     = 1'b0;
            IMM_MUX   = 1'b0;
            SRAM_OUT  = 1'b0;
            RA_BUF    = 1'b0;
            rSrc      = 4'h0;
            rDst      = 4'h0;
            aluOp     = ALUOp_NOP;
            imm       = 16'h0000;
            pc        = 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

`ifdef CPU_CONTROL_MEM_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        waiting;

    // Counts consecutive un-acked access cycles; restarts on every new access.
    always_comb begin
        waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ack;
        tmo     = waiting && (cnt_q == 16'(TIMEOUT_CYC - 1));
        cnt_d   = (waiting && !tmo) ? cnt_q + 16'd1 : 16'h0000;
        err_d   = err_q | tmo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'h0000;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q & ~rst;
`else
    assign tmo     = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule
